booth_mul_vr: RTL and testbench
===============================

// Module: booth_mul_vr
// PURPOSE
//  Parametrised radix-2 Booth sequential multiplier with valid/ready on both sides.
//  Supports a per-transaction signed/unsigned mode and holds its result under back-pressure.
//  Sits between an operand producer and a result consumer in the val_ready_seq_mul subsystem.
//  Successor to the fixed 16-bit datapath/controller pair; FSM and datapath live in one block.
// PARAMETERS
//  WIDTH   16                   operand width in bits (>=2)
//  CNT_W   $clog2(WIDTH+2)      iteration counter width (derived, do not override)
// PORTS
//  clk           in   1        clock, all state updates on posedge
//  rst           in   1        asynchronous reset, active-low
//  flush         in   1        synchronous abort; returns to IDLE, result discarded
//  src_valid     in   1        operand beat valid
//  src_ready     out  1        block can accept an operand beat
//  multiplicand  in   WIDTH    operand A, captured on src handshake
//  multiplier    in   WIDTH    operand B, captured on src handshake
//  signed_mode   in   1        1: two's-complement operands; 0: unsigned; captured with operands
//  dst_valid     out  1        product valid
//  dst_ready     in   1        consumer accepts product
//  product       out  2*WIDTH  result; stable while dst_valid=1 && dst_ready=0
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, src_ready=1, dst_valid=0, product=0, all internal regs=0.
//  Internal operand width N=WIDTH+1. Operands are sign-extended (signed_mode=1) or
//   zero-extended (0) to N bits at capture.
//  Datapath regs: BR[N], AC[N], QR[N], Q1 (Q[-1]), cnt[CNT_W], mode bit.
//  FSM states:
//   IDLE: src_ready=1. On src_valid&&src_ready, load BR=ext(A), QR=ext(B), AC=0, Q1=0, cnt=0.
//         Go to BUSY.
//   BUSY: src_ready=0. Each cycle apply one Booth step, cnt++.
//         {QR[0],Q1}=01: AC+=BR; 10: AC-=BR; 00/11: no op.
//         Then arithmetic right shift of {AC,QR,Q1} by 1; AC MSB is replicated.
//         Add/sub is N bits wide and wraps; no overflow flag.
//         On the step where cnt==N-1 (the Nth step), go to DONE.
//         Register product = low 2*WIDTH bits of the shifted {AC,QR} on that same edge.
//   DONE: dst_valid=1. On dst_ready go to IDLE; dst_valid drops on the next edge.
//  Latency: dst_valid rises exactly WIDTH+1 edges after the accepting edge.
//   Throughput is 1 product per WIDTH+3 cycles minimum.
//  src_ready is a function of state only; no combinational path from dst_ready.
//  src_ready is 0 in BUSY and DONE (no overlap of a new operand with a held result).
//  Back-pressure: in DONE with dst_ready=0, product and dst_valid hold indefinitely.
//  flush=1 (any state): next edge -> IDLE, dst_valid=0. The product reg keeps its old value,
//   which is don't-care. flush takes priority over a simultaneous src or dst handshake;
//   that beat is dropped.
//  Operand inputs and signed_mode are ignored outside the IDLE handshake.
//   Changing them mid-operation has no effect.
//  Reset mid-operation: immediate return to the reset state; the in-flight op is lost.
//  Corner results: signed -2^(W-1) * -2^(W-1) = +2^(2W-2) (fits);
//   unsigned (2^W-1)^2 fits in 2W bits.
// STRUCTURE
//  Package booth_mul_pkg:
//   typedef enum logic [1:0] {IDLE, BUSY, DONE} booth_state_t;
//   typedef enum logic [1:0] {OP_NOP, OP_ADD, OP_SUB} booth_op_t;
//   function booth_decode({Qn,Qn+1}) -> booth_op_t.
//  Sub-module booth_step #(N): combinational. Inputs ac, qr, q1, br.
//   Outputs next ac, qr, q1 (add/sub, then arithmetic shift). Instantiated once.
//  Top level holds the FSM, counter, capture/extension logic and output register.
// TESTING
//  1 signed, W=16: A=3, B=-5 -> product=32'hFFFF_FFF1, dst_valid exactly 17 edges after accept.
//  2 signed: A=B=16'h8000 -> 32'h4000_0000. Unsigned: A=B=16'hFFFF -> 32'hFFFE_0001.
//    Unsigned A=16'h8000, B=2 -> 32'h0001_0000.
//  3 back-pressure: hold dst_ready=0 for 10 cycles in DONE.
//    product/dst_valid stable, src_ready=0 throughout; release -> IDLE next edge.
//  4 back-to-back with dst_ready=1 and src_valid=1 always:
//    products 7*6=42, -1*-1=1 in order, no beat lost or duplicated.
//  5 assert rst=0 mid-BUSY (cnt=8) -> outputs at reset values immediately.
//    A new op after release gives the correct result.
//  6 flush in BUSY and in DONE (with dst_ready=1 on the same cycle) -> IDLE, no dst handshake.
//    Plus a random signed/unsigned sweep at WIDTH=8 and WIDTH=16 vs a reference model.

Source files
------------

// File: rtl/booth_mul_vr_pkg.sv
// Shared types for the valid/ready radix-2 Booth multiplier.
// Holds the FSM state encoding and the Booth pair decoder.
package booth_mul_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } booth_state_t;

    typedef enum logic [1:0] {
        OP_NOP,
        OP_ADD,
        OP_SUB
    } booth_op_t;

    function automatic booth_op_t booth_decode(input logic [1:0] i_pair);
        booth_op_t w_op;
        w_op = OP_NOP;
        unique case (i_pair)
            2'b01:   w_op = OP_ADD;
            2'b10:   w_op = OP_SUB;
            default: w_op = OP_NOP;
        endcase
        return w_op;
    endfunction

endpackage

// File: rtl/booth_mul_vr_if.sv
// Operand and result valid/ready bundle for booth_mul_vr.
// The master side produces operands and consumes products.
interface booth_mul_vr_if #(
    parameter int WIDTH = 16
) ();

    logic               src_valid;
    logic               src_ready;
    logic [WIDTH-1:0]   multiplicand;
    logic [WIDTH-1:0]   multiplier;
    logic               signed_mode;
    logic               dst_valid;
    logic               dst_ready;
    logic [2*WIDTH-1:0] product;

    modport master (
        output src_valid,
        output multiplicand,
        output multiplier,
        output signed_mode,
        output dst_ready,
        input  src_ready,
        input  dst_valid,
        input  product
    );

    modport slave (
        input  src_valid,
        input  multiplicand,
        input  multiplier,
        input  signed_mode,
        input  dst_ready,
        output src_ready,
        output dst_valid,
        output product
    );

endinterface

// File: rtl/booth_mul_vr_step.sv
// One combinational Booth iteration: add/sub BR into AC,
// then arithmetic shift of {AC,QR,Q1} right by one bit.
module booth_step
    import booth_mul_pkg::*;
#(
    parameter int N = 17
) (
    input  logic [N-1:0] i_ac,
    input  logic [N-1:0] i_qr,
    input  logic         i_q1,
    input  logic [N-1:0] i_br,
    output logic [N-1:0] o_ac,
    output logic [N-1:0] o_qr,
    output logic         o_q1
);

    logic [N-1:0] w_sum;

    always_comb begin
        w_sum = i_ac;
        unique case (booth_decode({i_qr[0], i_q1}))
            OP_ADD:  w_sum = i_ac + i_br;
            OP_SUB:  w_sum = i_ac - i_br;
            default: w_sum = i_ac;
        endcase
    end

    assign o_ac = {w_sum[N-1], w_sum[N-1:1]};
    assign o_qr = {w_sum[0], i_qr[N-1:1]};
    assign o_q1 = i_qr[0];

endmodule

// File: rtl/booth_mul_vr.sv
// Sequential radix-2 Booth multiplier with valid/ready on both sides.
// One extra operand bit lets the same datapath handle unsigned inputs.
module booth_mul_vr
    import booth_mul_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 2)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    booth_mul_vr_if.slave bus
);

    localparam int N = WIDTH + 1;

    booth_state_t       r_state;
    booth_state_t       w_state_d;
    logic [N-1:0]       r_br;
    logic [N-1:0]       r_ac;
    logic [N-1:0]       r_qr;
    logic               r_q1;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_product;

    logic [N-1:0]       w_ac_n;
    logic [N-1:0]       w_qr_n;
    logic               w_q1_n;
    logic [N-1:0]       w_a_ext;
    logic [N-1:0]       w_b_ext;
    logic               w_src_hs;
    logic               w_last;

    assign w_a_ext = {bus.signed_mode & bus.multiplicand[WIDTH-1],
                      bus.multiplicand};
    assign w_b_ext = {bus.signed_mode & bus.multiplier[WIDTH-1],
                      bus.multiplier};

    assign w_src_hs = (r_state == IDLE) && bus.src_valid;
    assign w_last   = (r_cnt == CNT_W'(WIDTH));

    booth_step #(
        .N (N)
    ) u_step (
        .i_ac (r_ac),
        .i_qr (r_qr),
        .i_q1 (r_q1),
        .i_br (r_br),
        .o_ac (w_ac_n),
        .o_qr (w_qr_n),
        .o_q1 (w_q1_n)
    );

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            IDLE:    if (bus.src_valid) w_state_d = BUSY;
            BUSY:    if (w_last) w_state_d = DONE;
            DONE:    if (bus.dst_ready) w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
        if (flush) w_state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_d;
    end

    // Flush freezes the datapath; stale contents are reloaded on the next accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_br      <= '0;
            r_ac      <= '0;
            r_qr      <= '0;
            r_q1      <= 1'b0;
            r_cnt     <= '0;
            r_product <= '0;
        end else if (!flush) begin
            if (w_src_hs) begin
                r_br  <= w_a_ext;
                r_qr  <= w_b_ext;
                r_ac  <= '0;
                r_q1  <= 1'b0;
                r_cnt <= '0;
            end else if (r_state == BUSY) begin
                r_ac  <= w_ac_n;
                r_qr  <= w_qr_n;
                r_q1  <= w_q1_n;
                r_cnt <= r_cnt + CNT_W'(1);
                if (w_last) r_product <= {w_ac_n[N-3:0], w_qr_n};
            end
        end
    end

    assign bus.src_ready = (r_state == IDLE);
    assign bus.dst_valid = (r_state == DONE);
    assign bus.product   = r_product;

endmodule

// File: tb/tb_booth_mul_vr.sv
// Directed and swept checks of booth_mul_vr at WIDTH=16 and WIDTH=8.
// Expected products are hand constants or a longint reference model.
module tb_booth_mul_vr;

    logic clk;
    logic rst;
    logic flush;

    int errors;
    int checks;

    booth_mul_vr_if #(.WIDTH(16)) b16 ();
    booth_mul_vr_if #(.WIDTH(8))  b8 ();

    booth_mul_vr #(.WIDTH(16)) dut16 (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (b16.slave)
    );

    booth_mul_vr #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (b8.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start16(input logic [15:0] a, input logic [15:0] b,
                           input logic m);
        b16.src_valid    = 1'b1;
        b16.multiplicand = a;
        b16.multiplier   = b;
        b16.signed_mode  = m;
        tick();
        b16.src_valid    = 1'b0;
    endtask

    task automatic wait_dv16(output int n);
        n = 0;
        while (!b16.dst_valid && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic op16(input string tag, input logic [15:0] a,
                        input logic [15:0] b, input logic m,
                        input logic [31:0] exp);
        int n;
        start16(a, b, m);
        b16.multiplicand = ~a;
        b16.multiplier   = ~b;
        b16.signed_mode  = ~m;
        wait_dv16(n);
        chk({tag, "_lat"}, 64'(n), 64'd17);
        chk(tag, 64'(b16.product), 64'(exp));
        b16.dst_ready = 1'b1;
        tick();
        b16.dst_ready = 1'b0;
        chk({tag, "_drop"}, 64'(b16.dst_valid), 64'd0);
    endtask

    task automatic op8(input string tag, input logic [7:0] a,
                       input logic [7:0] b, input logic m,
                       input logic [15:0] exp);
        int n;
        b8.src_valid    = 1'b1;
        b8.multiplicand = a;
        b8.multiplier   = b;
        b8.signed_mode  = m;
        tick();
        b8.src_valid    = 1'b0;
        n = 0;
        while (!b8.dst_valid && n < 100) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'd9);
        chk(tag, 64'(b8.product), 64'(exp));
        b8.dst_ready = 1'b1;
        tick();
        b8.dst_ready = 1'b0;
    endtask

    function automatic logic [31:0] ref16(input logic [15:0] a,
                                          input logic [15:0] b,
                                          input logic m);
        longint sa;
        longint sb;
        sa = m ? longint'($signed(a)) : longint'(a);
        sb = m ? longint'($signed(b)) : longint'(b);
        return 32'(sa * sb);
    endfunction

    function automatic logic [15:0] ref8(input logic [7:0] a,
                                         input logic [7:0] b,
                                         input logic m);
        longint sa;
        longint sb;
        sa = m ? longint'($signed(a)) : longint'(a);
        sb = m ? longint'($signed(b)) : longint'(b);
        return 16'(sa * sb);
    endfunction

    initial begin
        logic [31:0] hold_p;
        logic [31:0] got[$];
        logic [15:0] pa[2];
        logic [15:0] pb[2];
        logic        sh;
        logic        dh;
        int          acc;
        int          n;
        logic [15:0] ra;
        logic [15:0] rb;
        logic [7:0]  sa8;
        logic [7:0]  sb8;
        logic        rm;

        errors = 0;
        checks = 0;
        rst    = 1'b0;
        flush  = 1'b0;
        b16.src_valid = 1'b0;
        b16.dst_ready = 1'b0;
        b16.multiplicand = '0;
        b16.multiplier   = '0;
        b16.signed_mode  = 1'b0;
        b8.src_valid  = 1'b0;
        b8.dst_ready  = 1'b0;
        b8.multiplicand = '0;
        b8.multiplier   = '0;
        b8.signed_mode  = 1'b0;

        repeat (2) tick();
        chk("rst_src_ready", 64'(b16.src_ready), 64'd1);
        chk("rst_dst_valid", 64'(b16.dst_valid), 64'd0);
        chk("rst_product", 64'(b16.product), 64'd0);
        chk("rst_product8", 64'(b8.product), 64'd0);
        rst = 1'b1;
        tick();

        op16("s_3x-5", 16'd3, 16'hFFFB, 1'b1, 32'hFFFF_FFF1);
        op16("s_min2", 16'h8000, 16'h8000, 1'b1, 32'h4000_0000);
        op16("u_max2", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001);
        op16("u_8000x2", 16'h8000, 16'd2, 1'b0, 32'h0001_0000);

        // back-pressure
        start16(16'd100, 16'd200, 1'b0);
        wait_dv16(n);
        chk("bp_lat", 64'(n), 64'd17);
        chk("bp_prod", 64'(b16.product), 64'd20000);
        hold_p = b16.product;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_hold_p", 64'(b16.product), 64'(hold_p));
            chk("bp_hold_v", 64'(b16.dst_valid), 64'd1);
            chk("bp_src_rdy", 64'(b16.src_ready), 64'd0);
        end
        b16.dst_ready = 1'b1;
        tick();
        b16.dst_ready = 1'b0;
        chk("bp_rel_v", 64'(b16.dst_valid), 64'd0);
        chk("bp_rel_idle", 64'(b16.src_ready), 64'd1);

        // back-to-back stream
        pa[0] = 16'd7;
        pb[0] = 16'd6;
        pa[1] = 16'hFFFF;
        pb[1] = 16'hFFFF;
        acc = 0;
        b16.dst_ready    = 1'b1;
        b16.src_valid    = 1'b1;
        b16.signed_mode  = 1'b1;
        b16.multiplicand = pa[0];
        b16.multiplier   = pb[0];
        for (int c = 0; c < 100 && got.size() < 2; c++) begin
            sh = b16.src_valid && b16.src_ready;
            dh = b16.dst_valid && b16.dst_ready;
            if (dh) got.push_back(b16.product);
            tick();
            if (sh) begin
                acc++;
                if (acc < 2) begin
                    b16.multiplicand = pa[acc];
                    b16.multiplier   = pb[acc];
                end else begin
                    b16.src_valid = 1'b0;
                end
            end
        end
        b16.src_valid = 1'b0;
        b16.dst_ready = 1'b0;
        chk("b2b_count", 64'(got.size()), 64'd2);
        chk("b2b_accepts", 64'(acc), 64'd2);
        if (got.size() == 2) begin
            chk("b2b_p0", 64'(got[0]), 64'd42);
            chk("b2b_p1", 64'(got[1]), 64'd1);
        end

        // reset mid-BUSY
        start16(16'd1234, 16'd567, 1'b0);
        repeat (8) tick();
        rst = 1'b0;
        #1;
        chk("mrst_src_rdy", 64'(b16.src_ready), 64'd1);
        chk("mrst_dst_v", 64'(b16.dst_valid), 64'd0);
        chk("mrst_prod", 64'(b16.product), 64'd0);
        #3;
        rst = 1'b1;
        tick();
        op16("mrst_after", 16'd1234, 16'd567, 1'b0, 32'd699678);

        // flush in BUSY
        start16(16'd9, 16'd9, 1'b0);
        repeat (4) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_busy_rdy", 64'(b16.src_ready), 64'd1);
        chk("fl_busy_v", 64'(b16.dst_valid), 64'd0);
        tick();
        chk("fl_busy_stay", 64'(b16.dst_valid), 64'd0);

        // flush in DONE with dst_ready
        start16(16'd11, 16'd13, 1'b0);
        wait_dv16(n);
        chk("fl_done_lat", 64'(n), 64'd17);
        flush = 1'b1;
        b16.dst_ready = 1'b1;
        tick();
        flush = 1'b0;
        b16.dst_ready = 1'b0;
        chk("fl_done_v", 64'(b16.dst_valid), 64'd0);
        chk("fl_done_rdy", 64'(b16.src_ready), 64'd1);
        op16("fl_after", 16'hFFFE, 16'd5, 1'b1, 32'hFFFF_FFF6);

        // sweeps against the reference model
        for (int i = 0; i < 12; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rm = 1'(i);
            op16("sw16", ra, rb, rm, ref16(ra, rb, rm));
        end
        op8("d8_min2", 8'h80, 8'h80, 1'b1, 16'h4000);
        op8("d8_umax", 8'hFF, 8'hFF, 1'b0, 16'hFE01);
        for (int i = 0; i < 16; i++) begin
            sa8 = 8'($urandom);
            sb8 = 8'($urandom);
            rm  = 1'(i);
            op8("sw8", sa8, sb8, rm, ref8(sa8, sb8, rm));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
